// File: rtl/leela_pix_pack.sv
`default_nettype none
//==============================================================================
// Module   : leela_pix_pack
// Desc     : Packs camera luminance bytes into big-endian 32-bit words, queues
//            them in a FWFT FIFO and writes them out over a Wishbone master.
//            Define LEELA_PIX_PACK_BURST_EN for 4-beat incrementing bursts;
//            otherwise classic single-word cycles are issued.
// Revision : 1.0 - initial release
//==============================================================================
module leela_pix_pack #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid_i,
    input  logic [7:0]  pix_dat_i,
    input  logic        frame_start_i,
    input  logic [31:0] base_adr_i,
    output logic [31:0] mc_adr_o,
    output logic [31:0] mc_dat_o,
    output logic        mc_we_o,
    output logic        mc_stb_o,
    output logic        mc_cyc_o,
    output logic [2:0]  mc_cti_o,
    output logic [1:0]  mc_bte_o,
    input  logic        mc_ack_i,
    output logic        ovf_o,
    output logic        busy_o
);

    localparam int               c_DEPTH_I = 2**FIFO_AW;
    localparam logic [FIFO_AW:0] c_DEPTH   = (FIFO_AW+1)'(c_DEPTH_I);
`ifdef LEELA_PIX_PACK_BURST_EN
    localparam logic [FIFO_AW:0] c_START_LEVEL = (FIFO_AW+1)'(4);
    localparam logic [2:0]       c_CTI_START   = 3'b010;
`else
    localparam logic [FIFO_AW:0] c_START_LEVEL = (FIFO_AW+1)'(1);
    localparam logic [2:0]       c_CTI_START   = 3'b000;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_byte_cnt;
    logic [23:0]          r_pack;
    logic [31:0]          r_mem [c_DEPTH_I];
    logic [FIFO_AW-1:0]   r_wptr;
    logic [FIFO_AW-1:0]   r_rptr;
    logic [FIFO_AW:0]     r_count;
    logic [31:0]          r_adr;
    logic                 r_flush_pend;
    logic                 r_ovf;
    logic                 r_cyc;
    logic                 r_stb;
    logic [2:0]           r_cti;
`ifdef LEELA_PIX_PACK_BURST_EN
    logic [1:0]           r_beat;
`endif

    logic        w_flush_now;
    logic        w_discard;
    logic        w_accept;
    logic        w_word_done;
    logic [31:0] w_word;
    logic        w_pop;
    logic        w_full;
    logic        w_push;
    logic        w_ovf_hit;
    logic        w_pend_next;

    // A frame start in any state discards the byte presented with it
    assign w_flush_now = (r_state == ST_IDLE && frame_start_i) || (r_state == ST_FLUSH);
    assign w_discard   = r_flush_pend || (r_state == ST_FLUSH) || frame_start_i;
    assign w_accept    = pix_valid_i && !w_discard;
    assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
    assign w_word      = {r_pack, pix_dat_i};
    assign w_pop       = r_stb && mc_ack_i;
    assign w_full      = (r_count == c_DEPTH);
    assign w_push      = w_word_done && (!w_full || w_pop);
    assign w_ovf_hit   = w_word_done && w_full && !w_pop;
    assign w_pend_next = r_flush_pend || frame_start_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_pack     <= 24'd0;
        end else if (w_flush_now) begin
            r_byte_cnt <= 2'd0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0:    r_pack[23:16] <= pix_dat_i;
                2'd1:    r_pack[15:8]  <= pix_dat_i;
                2'd2:    r_pack[7:0]   <= pix_dat_i;
                default: r_pack        <= r_pack;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush_now) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_flush_now) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_hit) begin
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_cti        <= 3'b000;
            r_adr        <= 32'd0;
            r_flush_pend <= 1'b0;
`ifdef LEELA_PIX_PACK_BURST_EN
            r_beat       <= 2'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        r_adr <= base_adr_i;
                    end else if (r_count >= c_START_LEVEL) begin
                        r_state <= ST_BURST;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_cti   <= c_CTI_START;
`ifdef LEELA_PIX_PACK_BURST_EN
                        r_beat  <= 2'd0;
`endif
                    end
                end
                ST_BURST: begin
                    if (frame_start_i) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mc_ack_i) begin
                        r_adr <= r_adr + 32'd4;
`ifdef LEELA_PIX_PACK_BURST_EN
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd2) begin
                            r_cti <= 3'b111;
                        end
                        if (r_beat == 2'd3) begin
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_cti   <= 3'b000;
                            r_state <= w_pend_next ? ST_FLUSH : ST_IDLE;
                        end
`else
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_cti   <= 3'b000;
                        r_state <= w_pend_next ? ST_FLUSH : ST_IDLE;
`endif
                    end
                end
                ST_FLUSH: begin
                    r_adr        <= base_adr_i;
                    r_flush_pend <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mc_adr_o = r_adr;
    assign mc_dat_o = r_mem[r_rptr];
    assign mc_we_o  = r_cyc;
    assign mc_cyc_o = r_cyc;
    assign mc_stb_o = r_stb;
    assign mc_cti_o = r_cti;
    assign mc_bte_o = 2'b00;
    assign ovf_o    = r_ovf;
    assign busy_o   = (r_count != '0) || (r_state != ST_IDLE) || r_flush_pend;

endmodule
`default_nettype wire

// File: doc/leela_pix_pack.md
LEELA_PIX_PACK -- requirements
Module: leela_pix_pack

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 Parameter FIFO_AW SHALL default to 4 and set the word-FIFO depth to 2**FIFO_AW words.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock (Wishbone clock)
- rst  in  1  async active-high reset
- pix_valid_i  in  1  pix_dat_i holds one camera luminance byte this cycle
- pix_dat_i  in  8  luminance byte
- frame_start_i  in  1  one-cycle pulse at start of frame
- base_adr_i  in  32  frame buffer byte address, word-aligned
- mc_adr_o  out  32  Wishbone address to memory controller camera port
- mc_dat_o  out  32  write data
- mc_we_o  out  1  write enable
- mc_stb_o  out  1  strobe
- mc_cyc_o  out  1  cycle
- mc_cti_o  out  3  cycle type
- mc_bte_o  out  2  burst type, constant 00
- mc_ack_i  in  1  acknowledge
- ovf_o  out  1  sticky FIFO overflow flag
- busy_o  out  1  FIFO non-empty, burst active, or flush pending

Function
REQ-004 Packer: the 1st accepted byte of a word SHALL go to bits 31:24, the 2nd to 23:16, the 3rd to 15:8 and the 4th to 7:0 (big-endian).
REQ-005 On the rising edge where the 4th byte is accepted, the completed word SHALL be pushed into the FIFO.
REQ-006 FIFO: first-word-fall-through; mc_dat_o SHALL equal the head word.
REQ-007 If a word completes while the FIFO is full, that word SHALL be dropped, ovf_o SHALL be set, and FIFO contents SHALL remain unchanged.
REQ-008 Simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-009 FSM states: IDLE, BURST, FLUSH.
REQ-010 IDLE -> BURST on the edge where FIFO count >= 4 (burst mode) or >= 1 (single mode); mc_cyc_o/mc_stb_o/mc_we_o SHALL assert from the following cycle.
REQ-011 In BURST, stb SHALL stay high through wait states; each mc_ack_i SHALL pop one word and add 4 to the address register (32-bit wrap, no saturation).
REQ-012 Burst mode: 4 beats; mc_cti_o SHALL be 010 on beats 0-2 and 111 on beat 3; cyc/stb/we SHALL deassert in the cycle after the 4th ack, and the FSM SHALL return to IDLE.
REQ-013 mc_adr_o SHALL present the address register.
REQ-014 frame_start_i in IDLE SHALL, at the next edge, clear the packer byte counter, empty the FIFO, load the address register from base_adr_i, and clear ovf_o.
REQ-015 frame_start_i in BURST SHALL set flush-pending; the current burst SHALL complete normally, then the FSM SHALL pass through FLUSH for one cycle to perform the REQ-014 actions, then go to IDLE.
REQ-016 While flush is pending or in FLUSH, pix_valid_i bytes SHALL be discarded.
REQ-017 frame_start_i and pix_valid_i in the same IDLE cycle: the flush SHALL take effect and the byte SHALL be discarded.
REQ-018 mc_we_o SHALL equal mc_cyc_o; no read cycles SHALL be issued.

Reset
REQ-019 Asynchronous reset SHALL force: FSM IDLE; FIFO empty; packer counter 0; address register 0; flush-pending 0; mc_cyc_o, mc_stb_o, mc_we_o, mc_cti_o, mc_bte_o, ovf_o and busy_o all 0; mc_adr_o 0.
REQ-020 A reset asserted mid-burst SHALL drop cyc/stb immediately (asynchronously); no further beats SHALL be issued.
REQ-021 The address register SHALL be loaded by the first frame_start_i after reset.

Configuration
REQ-022 Macro LEELA_PIX_PACK_BURST_EN defined: 4-beat incrementing bursts per REQ-012.
REQ-023 Macro LEELA_PIX_PACK_BURST_EN undefined: classic single-word cycles only, with mc_cti_o held at 000; each cycle SHALL end the cycle after its ack, and a new cycle SHALL start one idle cycle later if the FIFO is non-empty.

Verification
REQ-024 Bench SHALL cover: base 0x00100000, frame_start, bytes 01..10 with ack every cycle, burst mode -> one burst at 0x00100000..0x0010000C with data 01020304, 05060708, 090A0B0C, 0D0E0F10 and cti 010,010,010,111.
REQ-025 Bench SHALL cover: same stimulus with ack held low 3 cycles on beat 1 -> stb held, adr/dat stable during the wait, no beat lost.
REQ-026 Bench SHALL cover: ack never asserted, 17 words pushed with FIFO_AW=4 -> ovf_o=1 on the 17th word; a later frame_start clears ovf_o.
REQ-027 Bench SHALL cover: frame_start on beat 1 of a burst -> beats 2-3 still issued; FLUSH; address reloaded; bytes arriving before FLUSH ends are absent from memory.
REQ-028 Bench SHALL cover: LEELA_PIX_PACK_BURST_EN undefined, 8 bytes -> two single cycles, cti 000, addresses base and base+4.
REQ-029 Bench SHALL cover: rst asserted during beat 2 -> cyc/stb low without waiting for an edge; all outputs at their reset values.
